// File: rtl/draw_start_banner.sv
// Start-screen banner overlay.
// Draws a ROM-backed image over the incoming video stream inside a fixed
// rectangle. The banner blinks: it alternates between visible and hidden
// every BLINK_FRAMES frames while enable is held high.
//
// The video stream passes through three register stages:
//   stage 1 : rom_addr, in-box flag, sampled blink state, timing
//   stage 2 : ROM read in flight, everything else delayed
//   stage 3 : colour mux, registered outputs
//
// Streaming contract: there is no valid/ready handshake. Every input is
// accepted on every clk edge, and every output is the matching input
// delayed by exactly three clk edges.

module draw_start_banner #(
  parameter int          XPOS         = 200,
  parameter int          YPOS         = 276,
  parameter int          IMG_W        = 400,
  parameter int          IMG_H        = 48,
  parameter logic [11:0] KEY_COLOR    = 12'h0F0,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [14:0] rom_addr,
  input  logic [11:0] rom_pixel,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  // Box limits as 11-bit values, so the compares behave like the counters.
  localparam logic [10:0] X_LO = 11'(XPOS);
  localparam logic [10:0] X_HI = 11'(XPOS + IMG_W);
  localparam logic [10:0] Y_LO = 11'(YPOS);
  localparam logic [10:0] Y_HI = 11'(YPOS + IMG_H);

  localparam int                CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    HIDE = 2'd2
  } state_t;

  // One pixel's worth of video timing plus its background colour.
  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } px_t;

  // ---------------------------------------------------------------------
  // Frame tick and blink FSM
  // ---------------------------------------------------------------------
  logic             vblnk_q;
  logic             frame_tick;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A frame starts on the rising edge of vertical blanking.
  assign frame_tick = vblnk_in & ~vblnk_q;

  // Registered copy of vblnk used for the edge detect.
  always_ff @(posedge clk) begin
    if (rst) vblnk_q <= 1'b0;
    else     vblnk_q <= vblnk_in;
  end

  // Blink state and frame counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; dropping enable wins over a coincident frame tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (frame_tick) begin
      case (state_q)
        IDLE: begin
          state_d = SHOW;
          cnt_d   = '0;
        end
        SHOW, HIDE: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = (state_q == SHOW) ? HIDE : SHOW;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1: box test, ROM address, blink state sample
  // ---------------------------------------------------------------------
  px_t         px_in;
  logic        in_box_d;
  logic [10:0] rel_x, rel_y;
  logic [14:0] rom_addr_d;

  // Bundle the incoming stream and compute the in-box ROM address.
  always_comb begin
    px_in      = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                   vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in, rgb: rgb_in};
    in_box_d   = (hcount_in >= X_LO) && (hcount_in < X_HI) &&
                 (vcount_in >= Y_LO) && (vcount_in < Y_HI);
    rel_x      = hcount_in - X_LO;
    rel_y      = vcount_in - Y_LO;
    // Product taken modulo 2^15, which equals truncating the full address.
    rom_addr_d = '0;
    if (in_box_d) begin
      rom_addr_d = 15'(rel_y) * 15'(IMG_W) + 15'(rel_x);
    end
  end

  logic [14:0] rom_addr_q;
  logic        box1_q, show1_q;
  px_t         px1_q;

  // Stage-1 registers; the blink state is frozen here for this pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr_q <= '0;
      box1_q     <= 1'b0;
      show1_q    <= 1'b0;
      px1_q      <= '0;
    end else begin
      rom_addr_q <= rom_addr_d;
      box1_q     <= in_box_d;
      show1_q    <= (state_q == SHOW);
      px1_q      <= px_in;
    end
  end

  assign rom_addr = rom_addr_q;

  // ---------------------------------------------------------------------
  // Stage 2: wait for the ROM word
  // ---------------------------------------------------------------------
  logic box2_q, show2_q;
  px_t  px2_q;

  // Stage-2 registers, aligned with rom_pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      box2_q  <= 1'b0;
      show2_q <= 1'b0;
      px2_q   <= '0;
    end else begin
      box2_q  <= box1_q;
      show2_q <= show1_q;
      px2_q   <= px1_q;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 3: colour mux
  // ---------------------------------------------------------------------
  logic draw;
  px_t  out_d, out_q;

  // Banner wins only when visible, inside the box, outside blanking and opaque.
  always_comb begin
    draw  = show2_q && box2_q && !px2_q.hblnk && !px2_q.vblnk &&
            (rom_pixel != KEY_COLOR);
    out_d = px2_q;
    if (draw) out_d.rgb = rom_pixel;
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) out_q <= '0;
    else     out_q <= out_d;
  end

  assign hcount_out = out_q.hcount;
  assign vcount_out = out_q.vcount;
  assign hsync_out  = out_q.hsync;
  assign vsync_out  = out_q.vsync;
  assign hblnk_out  = out_q.hblnk;
  assign vblnk_out  = out_q.vblnk;
  assign rgb_out    = out_q.rgb;

endmodule

// File: tb/tb_draw_start_banner.sv
// Testbench for draw_start_banner: directed scenarios followed by random
// video traffic, all checked against a frame-counting reference model.
module tb_draw_start_banner;

  localparam int          XPOS  = 200;
  localparam int          YPOS  = 276;
  localparam int          IMG_W = 400;
  localparam int          IMG_H = 48;
  localparam logic [11:0] KEY   = 12'h0F0;
  localparam int          BF    = 2;

  // ---------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst, enable;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in;
  logic [14:0] rom_addr;
  logic [11:0] rom_pixel;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  always #5 clk = ~clk;

  draw_start_banner #(
    .XPOS(XPOS), .YPOS(YPOS), .IMG_W(IMG_W), .IMG_H(IMG_H),
    .KEY_COLOR(KEY), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in),
    .rom_addr(rom_addr), .rom_pixel(rom_pixel),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  // Image ROM contents: every 7th word (offset 3) is transparent.
  function automatic logic [11:0] rom_fn(input int a);
    logic [11:0] w;
    if (a % 7 == 3) return KEY;
    w = 12'((a * 37 + 5) & 32'hFFF);
    if (w == KEY) w = w ^ 12'h001;
    return w;
  endfunction

  // Synchronous ROM: data one clk after the address.
  always @(posedge clk) rom_pixel <= rom_fn(int'(rom_addr));

  // ---------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  // Expected {hcount, vcount, hsync, vsync, hblnk, vblnk, rgb}, 3 cycles out.
  logic [37:0] exp_q[$];
  logic [14:0] exp_addr;
  bit          primed = 0;

  // Reference model: active flag plus number of frame ticks seen since the
  // banner was switched on. Frame n (1-based) is visible when
  // ((n-1)/BF) is even.
  bit m_active = 0;
  int m_n      = 0;
  bit m_prev_vb = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Driver: compare what is on the outputs now, apply one pixel, advance
  // the model, then move to the next falling edge.
  // ---------------------------------------------------------------------
  task automatic drive(input logic r, input logic en, input logic [10:0] h,
                       input logic [10:0] v, input logic hs, input logic vs,
                       input logic hb, input logic vb, input logic [11:0] rgb);
    logic [37:0] e;
    bit          inb, show, tick;
    int          addr;
    logic [11:0] word;

    if (primed) check("rom_addr", 64'(rom_addr), 64'(exp_addr));
    if (exp_q.size() == 3) begin
      e = exp_q.pop_front();
      check("timing", 64'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}),
            64'(e[37:12]));
      check("rgb", 64'(rgb_out), 64'(e[11:0]));
    end

    rst = r; enable = en; hcount_in = h; vcount_in = v;
    hsync_in = hs; vsync_in = vs; hblnk_in = hb; vblnk_in = vb; rgb_in = rgb;

    if (r) begin
      foreach (exp_q[i]) exp_q[i] = '0;
      exp_q.push_back('0);
      exp_addr  = '0;
      m_active  = 0;
      m_n       = 0;
      m_prev_vb = 0;
    end else begin
      inb  = (int'(h) >= XPOS) && (int'(h) < XPOS + IMG_W) &&
             (int'(v) >= YPOS) && (int'(v) < YPOS + IMG_H);
      addr = inb ? (((int'(v) - YPOS) * IMG_W + (int'(h) - XPOS)) % 32768) : 0;
      word = rom_fn(addr);
      show = m_active && (((m_n - 1) / BF) % 2 == 0);
      if (show && inb && !hb && !vb && word != KEY)
        exp_q.push_back({h, v, hs, vs, hb, vb, word});
      else
        exp_q.push_back({h, v, hs, vs, hb, vb, rgb});
      exp_addr = 15'(addr);

      tick      = vb && !m_prev_vb;
      m_prev_vb = vb;
      if (!en) begin
        m_active = 0;
        m_n      = 0;
      end else if (tick) begin
        if (!m_active) begin
          m_active = 1;
          m_n      = 1;
        end else begin
          m_n++;
        end
      end
    end
    primed = 1;
    @(negedge clk);
  endtask

  task automatic filler(input logic en);
    drive(1'b0, en, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0AA);
  endtask

  task automatic frame_tick(input logic en);
    drive(1'b0, en, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h0AA);
  endtask

  // One pixel, then two quiet cycles, then read the pixel's output colour.
  task automatic px_probe(input string tag, input logic en, input logic [10:0] h,
                          input logic [10:0] v, input logic hb, input logic [11:0] rgb,
                          input logic [11:0] exp);
    drive(1'b0, en, h, v, 1'b0, 1'b0, hb, 1'b0, rgb);
    filler(en);
    filler(en);
    check(tag, 64'(rgb_out), 64'(exp));
  endtask

  task automatic addr_probe(input logic [10:0] h, input logic [10:0] v, input logic [14:0] exp);
    drive(1'b0, 1'b0, h, v, 1'b0, 1'b0, 1'b0, 1'b0, 12'h321);
    check("addr_edge", 64'(rom_addr), 64'(exp));
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  localparam logic [10:0] PH = 11'(XPOS + 7);
  localparam logic [10:0] PV = 11'(YPOS + 2);

  initial begin
    bit          shown [1:6] = '{1, 1, 0, 0, 1, 1};
    logic        r_en, r_vb, r_rst, r_hb;
    logic [10:0] h, v;

    rst = 1'b1; enable = 1'b0; hcount_in = '0; vcount_in = '0;
    hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0; rgb_in = '0;
    @(negedge clk);

    // Reset state.
    for (int i = 0; i < 3; i++)
      drive(1'b1, 1'b0, 11'd33, 11'd44, 1'b1, 1'b1, 1'b1, 1'b0, 12'hFFF);
    check("reset_rgb", 64'(rgb_out), 64'd0);
    check("reset_hcount", 64'(hcount_out), 64'd0);
    check("reset_addr", 64'(rom_addr), 64'd0);

    // Three-cycle latency with the banner off.
    drive(1'b0, 1'b0, 11'd5, 11'd9, 1'b1, 1'b0, 1'b1, 1'b0, 12'h123);
    filler(1'b0);
    filler(1'b0);
    check("lat_rgb", 64'(rgb_out), 64'h123);
    check("lat_hcount", 64'(hcount_out), 64'd5);
    check("lat_vcount", 64'(vcount_out), 64'd9);
    check("lat_sync", 64'({hsync_out, vsync_out}), 64'b10);
    check("lat_blank", 64'({hblnk_out, vblnk_out}), 64'b10);

    // Box edges and addressing.
    addr_probe(11'(XPOS - 1), 11'(YPOS + 4), 15'd0);
    addr_probe(11'(XPOS + IMG_W), 11'(YPOS + 4), 15'd0);
    addr_probe(11'(XPOS + 50), 11'(YPOS + IMG_H), 15'd0);
    addr_probe(11'(XPOS + IMG_W - 1), 11'(YPOS + IMG_H - 1), 15'd19199);
    addr_probe(PH, PV, 15'd807);

    // Enabled but no tick yet: still hidden.
    px_probe("idle_hidden", 1'b1, PH, PV, 1'b0, 12'h123, 12'h123);

    // Blink sequence over six frames.
    for (int f = 1; f <= 6; f++) begin
      frame_tick(1'b1);
      px_probe($sformatf("blink_f%0d", f), 1'b1, PH, PV, 1'b0, 12'h123,
               shown[f] ? rom_fn(807) : 12'h123);
    end

    // Transparent word and horizontal blanking inside the box (frame 6 visible).
    px_probe("key_color", 1'b1, 11'(XPOS + 3), 11'(YPOS), 1'b0, 12'h456, 12'h456);
    px_probe("hblank", 1'b1, PH, PV, 1'b1, 12'h789, 12'h789);
    px_probe("visible_again", 1'b1, PH, PV, 1'b0, 12'h789, rom_fn(807));

    // Disable coincides with a tick at the last count: must go idle.
    frame_tick(1'b0);
    px_probe("prio_idle", 1'b1, PH, PV, 1'b0, 12'h123, 12'h123);
    frame_tick(1'b1);
    px_probe("prio_restart", 1'b1, PH, PV, 1'b0, 12'h123, rom_fn(807));

    // Reset while visible.
    drive(1'b0, 1'b1, PH, PV, 1'b1, 1'b1, 1'b0, 1'b0, 12'h5A5);
    drive(1'b0, 1'b1, PH, PV, 1'b1, 1'b1, 1'b0, 1'b0, 12'h5A5);
    drive(1'b1, 1'b1, PH, PV, 1'b1, 1'b1, 1'b0, 1'b0, 12'h5A5);
    check("rst_show_rgb", 64'(rgb_out), 64'd0);
    check("rst_show_hcount", 64'(hcount_out), 64'd0);
    check("rst_show_addr", 64'(rom_addr), 64'd0);
    px_probe("post_rst_hidden", 1'b1, PH, PV, 1'b0, 12'h123, 12'h123);
    frame_tick(1'b1);
    px_probe("post_rst_tick", 1'b1, PH, PV, 1'b0, 12'h123, rom_fn(807));

    // Random traffic.
    r_en = 1'b1;
    r_vb = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) r_en = ~r_en;
      if ($urandom_range(0, 19) == 0)  r_vb = ~r_vb;
      r_rst = ($urandom_range(0, 999) == 0);
      r_hb  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 1) begin
        h = 11'(XPOS - 3 + int'($urandom_range(0, IMG_W + 5)));
        v = 11'(YPOS - 3 + int'($urandom_range(0, IMG_H + 5)));
      end else begin
        h = 11'($urandom_range(0, 2047));
        v = 11'($urandom_range(0, 2047));
      end
      drive(r_rst, r_en, h, v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            r_hb, r_vb, 12'($urandom_range(0, 4095)));
    end

    // Flush the pipeline so every queued pixel is compared.
    for (int i = 0; i < 4; i++) filler(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
